// File: rtl/reg_file_sb_if.sv
// Bundle of the register-file read, write, reserve and dump signals.
// Latency: none (pure wiring).
// Backpressure: dump stream uses dump_valid/dump_ready; reserve uses rsv_valid/rsv_ready.
interface reg_file_sb_if #(
  parameter int ID_W   = 8,
  parameter int DATA_W = 64,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  logic [NRD*ID_W-1:0]   rd_id;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NRD-1:0]        rd_err;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ID_W-1:0]   wr_id;
  logic [NWR*DATA_W-1:0] wr_data;
  logic                  rsv_valid;
  logic [ID_W-1:0]       rsv_id;
  logic                  rsv_ready;
  logic                  dump_start;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [ID_W-1:0]       dump_id;
  logic [DATA_W-1:0]     dump_data;
  logic                  dump_done;

  // Requester side: drives IDs, writes, reservations and dump control.
  modport master (
    output rd_id, wr_en, wr_id, wr_data, rsv_valid, rsv_id, dump_start, dump_ready,
    input  rd_data, rd_busy, rd_err, rsv_ready, dump_valid, dump_id, dump_data, dump_done
  );

  // Register-file side.
  modport slave (
    input  rd_id, wr_en, wr_id, wr_data, rsv_valid, rsv_id, dump_start, dump_ready,
    output rd_data, rd_busy, rd_err, rsv_ready, dump_valid, dump_id, dump_data, dump_done
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard and a register-dump sequencer.
// Latency: reads and dump data are combinational with write-first bypass; writes land at the edge.
// Backpressure: dump entry holds while dump_ready=0; reserve refused while target is busy or out of range.
module reg_file_sb #(
  parameter int NREGS  = 18,
  parameter int DATA_W = 64,
  parameter int ID_W   = 8,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input logic         clk,
  input logic         rst_n,
  reg_file_sb_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DUMP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   dump_id_q, dump_id_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic              rsv_ok;

  // Lookup ports: 0..NRD-1 are the read ports, index NRD is the dump port.
  logic [ID_W-1:0]   rp_id   [NRD+1];
  logic [DATA_W-1:0] rp_data [NRD+1];
  logic              rp_hit  [NRD+1];

  // Collect the IDs looked up this cycle.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rp_id[p] = bus.rd_id[p*ID_W +: ID_W];
    end
    rp_id[NRD] = dump_id_q;
  end

  // Stored value per lookup, overridden by same-cycle writes; later ports take priority.
  always_comb begin
    for (int i = 0; i <= NRD; i++) begin
      rp_data[i] = '0;
      rp_hit[i]  = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        if (rp_id[i] == ID_W'(r)) begin
          rp_data[i] = regs_q[r];
          rp_hit[i]  = 1'b1;
        end
      end
      for (int w = 0; w < NWR; w++) begin
        if (rp_hit[i] && bus.wr_en[w] && bus.wr_id[w*ID_W +: ID_W] == rp_id[i]) begin
          rp_data[i] = bus.wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read-port outputs; busy comes from registered scoreboard only.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    bus.rd_err  = '0;
    for (int p = 0; p < NRD; p++) begin
      bus.rd_data[p*DATA_W +: DATA_W] = rp_data[p];
      bus.rd_err[p] = !rp_hit[p];
      for (int r = 0; r < NREGS; r++) begin
        if (rp_id[p] == ID_W'(r)) bus.rd_busy[p] = busy_q[r];
      end
    end
  end

  // Reservation is accepted only for an in-range, currently idle register.
  always_comb begin
    rsv_ok = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (bus.rsv_id == ID_W'(r) && !busy_q[r]) rsv_ok = 1'b1;
    end
    bus.rsv_ready = rsv_ok;
  end

  // Register and scoreboard update: writes clear busy, an accepted reserve sets it last so it wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        for (int w = 0; w < NWR; w++) begin
          if (bus.wr_en[w] && bus.wr_id[w*ID_W +: ID_W] == ID_W'(r)) begin
            regs_q[r] <= bus.wr_data[w*DATA_W +: DATA_W];
            busy_q[r] <= 1'b0;
          end
        end
        if (bus.rsv_valid && rsv_ok && bus.rsv_id == ID_W'(r)) busy_q[r] <= 1'b1;
      end
    end
  end

  // Dump sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dump_id_q <= '0;
    end else begin
      state_q   <= state_d;
      dump_id_q <= dump_id_d;
    end
  end

  // Dump sequencer next state and stream outputs; ID/data are driven only while streaming.
  always_comb begin
    state_d        = state_q;
    dump_id_d      = dump_id_q;
    bus.dump_valid = 1'b0;
    bus.dump_done  = 1'b0;
    bus.dump_id    = '0;
    bus.dump_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.dump_start) begin
          state_d   = S_DUMP;
          dump_id_d = '0;
        end
      end
      S_DUMP: begin
        bus.dump_valid = 1'b1;
        bus.dump_id    = dump_id_q;
        bus.dump_data  = rp_hit[NRD] ? rp_data[NRD] : '0;
        if (bus.dump_ready) begin
          if (dump_id_q == ID_W'(NREGS-1)) begin
            state_d   = S_DONE;
            dump_id_d = '0;
          end else begin
            dump_id_d = dump_id_q + ID_W'(1);
          end
        end
      end
      S_DONE: begin
        bus.dump_done = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
